// File: rtl/usb_tx_serializer.sv
`default_nettype none
// ============================================================================
// usb_tx_serializer : USB full-speed NRZI serializer with SYNC, bit stuffing, EOP
// Revision: 1.0
// ============================================================================
module usb_tx_serializer #(
    parameter int CLKS_PER_BIT = 8,
    parameter int STUFF_LEN    = 6,
    parameter int EOP_SE0_BITS = 2,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_start_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    input  logic              tx_last_i,
    output logic              tx_ready_o,
    output logic              d_plus_o,
    output logic              d_minus_o,
    output logic              busy_o,
    output logic              eop_done_o,
    output logic              underrun_o
);
    localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int ONES_W = $clog2(STUFF_LEN + 1);
    localparam int REM_W  = $clog2(DATA_W + 1);
    localparam int EOP_W  = (EOP_SE0_BITS > 1) ? $clog2(EOP_SE0_BITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SYNC    = 3'd1,
        S_DATA    = 3'd2,
        S_EOP_SE0 = 3'd3,
        S_EOP_J   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          sync_q, sync_d;
    logic [ONES_W-1:0]   ones_q, ones_d;
    logic [DATA_W-1:0]   sh_q, sh_d, buf_q, buf_d;
    logic [REM_W-1:0]    rem_q, rem_d;
    logic [EOP_W-1:0]    eop_q, eop_d;
    logic                buf_full_q, buf_full_d, last_acc_q, last_acc_d;
    logic                dp_q, dp_d, dm_q, dm_d;
    logic                eop_done_q, eop_done_d, underrun_q, underrun_d;

    logic                bit_end, stuff, accept, have_word, bit_valid, bit_val;
    logic [DATA_W-1:0]   src_sh;
    logic [REM_W-1:0]    src_rem;

    assign busy_o     = (state_q != S_IDLE);
    assign tx_ready_o = ((state_q == S_SYNC) || (state_q == S_DATA)) && !buf_full_q && !last_acc_q;
    assign d_plus_o   = dp_q;
    assign d_minus_o  = dm_q;
    assign eop_done_o = eop_done_q;
    assign underrun_o = underrun_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sync_d     = sync_q;
        ones_d     = ones_q;
        sh_d       = sh_q;
        buf_d      = buf_q;
        rem_d      = rem_q;
        eop_d      = eop_q;
        buf_full_d = buf_full_q;
        last_acc_d = last_acc_q;
        dp_d       = dp_q;
        dm_d       = dm_q;
        eop_done_d = 1'b0;
        underrun_d = 1'b0;
        bit_valid  = 1'b0;
        bit_val    = 1'b0;
        src_sh     = sh_q;
        src_rem    = rem_q;

        bit_end   = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
        stuff     = (ones_q == ONES_W'(STUFF_LEN));
        accept    = tx_valid_i && tx_ready_o;
        have_word = buf_full_q || accept;

        if (accept) begin
            buf_d      = tx_data_i;
            buf_full_d = 1'b1;
            if (tx_last_i) begin
                last_acc_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                cnt_d      = '0;
                buf_full_d = 1'b0;
                last_acc_d = 1'b0;
                if (tx_start_i) begin
                    // First SYNC bit is a 0, so the line toggles from J to K at once.
                    state_d = S_SYNC;
                    sync_d  = '0;
                    ones_d  = '0;
                    rem_d   = '0;
                    dp_d    = 1'b0;
                    dm_d    = 1'b1;
                end
            end
            S_SYNC, S_DATA: begin
                cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
                if (bit_end) begin
                    if ((state_q == S_SYNC) && (sync_q != 3'd7)) begin
                        sync_d    = sync_q + 3'd1;
                        bit_valid = 1'b1;
                        bit_val   = (sync_q == 3'd6);
                    end else begin
                        // Word exhausted: pull the next one, bypassing the buffer if it arrives now.
                        if ((rem_q == '0) && have_word) begin
                            src_sh     = buf_full_q ? buf_q : tx_data_i;
                            src_rem    = REM_W'(DATA_W);
                            buf_full_d = 1'b0;
                        end
                        if (stuff) begin
                            bit_valid = 1'b1;
                            bit_val   = 1'b0;
                            sh_d      = src_sh;
                            rem_d     = src_rem;
                            state_d   = S_DATA;
                        end else if (src_rem != '0) begin
                            bit_valid = 1'b1;
                            bit_val   = src_sh[0];
                            sh_d      = src_sh >> 1;
                            rem_d     = src_rem - REM_W'(1);
                            state_d   = S_DATA;
                        end else begin
                            state_d    = S_EOP_SE0;
                            eop_d      = '0;
                            dp_d       = 1'b0;
                            dm_d       = 1'b0;
                            underrun_d = !last_acc_q;
                        end
                    end
                end
            end
            S_EOP_SE0: begin
                cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
                if (bit_end) begin
                    if (eop_q == EOP_W'(EOP_SE0_BITS - 1)) begin
                        state_d = S_EOP_J;
                        dp_d    = 1'b1;
                        dm_d    = 1'b0;
                    end else begin
                        eop_d = eop_q + EOP_W'(1);
                    end
                end
            end
            S_EOP_J: begin
                cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
                if (bit_end) begin
                    state_d    = S_IDLE;
                    eop_done_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                dp_d    = 1'b1;
                dm_d    = 1'b0;
            end
        endcase

        if (bit_valid) begin
            dp_d   = bit_val ? dp_q : ~dp_q;
            dm_d   = ~dp_d;
            ones_d = bit_val ? ones_q + ONES_W'(1) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sync_q     <= '0;
            ones_q     <= '0;
            sh_q       <= '0;
            buf_q      <= '0;
            rem_q      <= '0;
            eop_q      <= '0;
            buf_full_q <= 1'b0;
            last_acc_q <= 1'b0;
            dp_q       <= 1'b1;
            dm_q       <= 1'b0;
            eop_done_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sync_q     <= sync_d;
            ones_q     <= ones_d;
            sh_q       <= sh_d;
            buf_q      <= buf_d;
            rem_q      <= rem_d;
            eop_q      <= eop_d;
            buf_full_q <= buf_full_d;
            last_acc_q <= last_acc_d;
            dp_q       <= dp_d;
            dm_q       <= dm_d;
            eop_done_q <= eop_done_d;
            underrun_q <= underrun_d;
        end
    end

endmodule
`default_nettype wire
